mod_enc_row2col: RTL and testbench



---
 rtl/aes_enc_pkg.sv | 19 +
 rtl/mod_enc_colbank.sv | 31 +++
 rtl/mod_enc_row2col.sv | 108 ++++++++++
 tb/tb_mod_enc_row2col.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/aes_enc_pkg.sv
// Shared types for the AES encryption datapath: byte/row/column types and the row-to-column FSM states.
// Bank count follows ROW2COL_PINGPONG_EN (two banks when defined, one otherwise).
package aes_enc_pkg;

  localparam int unsigned N = 4;

  typedef logic [7:0]        byte_t;
  typedef byte_t [N-1:0]     row_t;
  typedef byte_t [N-1:0]     col_t;

  typedef enum logic {FILL, DRAIN} row2col_state_e;

`ifdef ROW2COL_PINGPONG_EN
  localparam int unsigned NBANK = 2;
`else
  localparam int unsigned NBANK = 1;
`endif

endpackage

// File: rtl/mod_enc_colbank.sv
// One 4x4 byte state bank: row-wise write port, column-wise read port, async clear.
module mod_enc_colbank
  import aes_enc_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       we,
  input  logic [1:0] wr_idx,
  input  row_t       wr_row,
  input  logic [1:0] rd_idx,
  output col_t       rd_col
);

  row_t [N-1:0] mat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mat <= '0;
    end else if (we) begin
      mat[wr_idx] <= wr_row;
    end
  end

  always_comb begin
    rd_col = '0;
    for (int unsigned r = 0; r < N; r++) begin
      rd_col[r] = mat[r][rd_idx];
    end
  end

endmodule

// File: rtl/mod_enc_row2col.sv
// ShiftRows -> MixColumns adapter: collects four rows, emits the state column by column.
// ROW2COL_PINGPONG_EN selects two banks so one block fills while the previous one drains.
module mod_enc_row2col #(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [N-1:0][7:0] in_row,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0][7:0] out_col,
  output logic [1:0]        out_col_idx,
  output logic              blk_done,
  output logic              ovf
);

  import aes_enc_pkg::row_t;
  import aes_enc_pkg::col_t;
  import aes_enc_pkg::row2col_state_e;
  import aes_enc_pkg::FILL;
  import aes_enc_pkg::DRAIN;
  import aes_enc_pkg::NBANK;

  localparam logic PP = (NBANK == 2);

  row2col_state_e state, state_nxt;
  logic [1:0] wr_row, col;
  logic [1:0] full, full_nxt;
  logic       wr_bank, wr_bank_nxt, rd_bank, rd_bank_nxt;
  logic       acc, xfer, last;
  logic [1:0] bank_we;
  col_t       rd_col [2];

  // Bank occupancy drives both directions; FILL/DRAIN mirrors whether the read bank holds a block.
  always_comb begin
    in_ready    = !full[wr_bank];
    out_valid   = (state == DRAIN);
    acc         = in_valid && in_ready;
    xfer        = out_valid && out_ready;
    last        = xfer && (col == 2'd3);
    full_nxt    = full;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    if (last) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = rd_bank ^ PP;
    end
    if (acc && (wr_row == 2'd3)) begin
      full_nxt[wr_bank] = 1'b1;
      wr_bank_nxt       = wr_bank ^ PP;
    end
    state_nxt = full_nxt[rd_bank_nxt] ? DRAIN : FILL;
    bank_we   = '0;
    bank_we[wr_bank] = acc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= FILL;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_row   <= '0;
      col      <= '0;
      blk_done <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      full     <= full_nxt;
      wr_bank  <= wr_bank_nxt;
      rd_bank  <= rd_bank_nxt;
      blk_done <= last;
      if (acc)  wr_row <= wr_row + 2'd1;
      if (xfer) col    <= col + 2'd1;
      if (in_valid && !in_ready) ovf <= 1'b1;
    end
  end

  mod_enc_colbank u_bank0 (
    .clk    (clk),
    .resetn (resetn),
    .we     (bank_we[0]),
    .wr_idx (wr_row),
    .wr_row (row_t'(in_row)),
    .rd_idx (col),
    .rd_col (rd_col[0])
  );

`ifdef ROW2COL_PINGPONG_EN
  mod_enc_colbank u_bank1 (
    .clk    (clk),
    .resetn (resetn),
    .we     (bank_we[1]),
    .wr_idx (wr_row),
    .wr_row (row_t'(in_row)),
    .rd_idx (col),
    .rd_col (rd_col[1])
  );
`else
  assign rd_col[1] = '0;
`endif

  assign out_col     = rd_col[rd_bank];
  assign out_col_idx = col;

endmodule

// File: tb/tb_mod_enc_row2col.sv
// Bench for mod_enc_row2col: directed scenarios plus random traffic against a row-queue transpose model.
module tb_mod_enc_row2col;

`ifdef ROW2COL_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic [3:0][7:0]  in_row;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0][7:0]  out_col;
  logic [1:0]       out_col_idx;
  logic             blk_done;
  logic             ovf;

  always #5 clk = ~clk;

  mod_enc_row2col #(.N(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_row      (in_row),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_col_idx (out_col_idx),
    .blk_done    (blk_done),
    .ovf         (ovf)
  );

  int checks   = 0;
  int failures = 0;

  // Model: accepted rows in arrival order; every 4 consecutive rows are one block.
  logic [31:0] rowq[$];
  int          m_col;
  logic        m_done;
  logic        m_ovf;
  int          blocks;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    rowq.delete();
    m_col  = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Enter and leave at the falling edge.
  task automatic do_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_col", 64'(out_col), 64'd0);
    chk("rst_out_col_idx", 64'(out_col_idx), 64'd0);
    chk("rst_blk_done", 64'(blk_done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycle(input logic iv, input logic [31:0] row, input logic ordy);
    int          pend;
    logic        m_ir, m_ov;
    logic [31:0] ecol;
    pend = rowq.size() / 4;
    m_ir = (pend < NB);
    m_ov = (pend > 0);
    chk("in_ready", 64'(in_ready), 64'(m_ir));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("blk_done", 64'(blk_done), 64'(m_done));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (m_ov) begin
      ecol = '0;
      for (int r = 0; r < 4; r++) ecol[r*8 +: 8] = rowq[r][m_col*8 +: 8];
      chk("out_col", 64'(out_col), 64'(ecol));
      chk("out_col_idx", 64'(out_col_idx), 64'(m_col));
    end
    in_valid  = iv;
    in_row    = row;
    out_ready = ordy;
    @(posedge clk);
    m_done = 1'b0;
    if (m_ov && ordy) begin
      m_col++;
      if (m_col == 4) begin
        m_col = 0;
        repeat (4) void'(rowq.pop_front());
        m_done = 1'b1;
        blocks++;
      end
    end
    if (iv && !m_ir) m_ovf = 1'b1;
    if (iv && m_ir)  rowq.push_back(row);
    @(negedge clk);
  endtask

  function automatic logic [31:0] seq_row(input int base);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(base + c);
    return v;
  endfunction

  initial begin
    blocks = 0;
    do_reset();

    // Rows byte c = 4r+c, drained with out_ready high
    for (int r = 0; r < 4; r++) cycle(1'b1, seq_row(4 * r), 1'b1);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // Stall 5 cycles on column 1
    for (int r = 0; r < 4; r++) cycle(1'b1, $urandom, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    repeat (5) cycle(1'b0, 32'h0, 1'b1);

    // Rows offered while draining
    for (int r = 0; r < 4; r++) cycle(1'b1, $urandom, 1'b1);
    cycle(1'b1, 32'hdeadbeef, 1'b0);
    cycle(1'b1, 32'hcafef00d, 1'b1);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // Reset after two rows: partial block discarded
    cycle(1'b1, 32'h11111111, 1'b1);
    cycle(1'b1, 32'h22222222, 1'b1);
    do_reset();
    for (int r = 0; r < 4; r++) cycle(1'b1, seq_row(16 * r + 8'h40), 1'b1);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // Eight rows back-to-back
    for (int r = 0; r < 8; r++) cycle(1'b1, $urandom, 1'b1);
    repeat (10) cycle(1'b0, 32'h0, 1'b1);

    // Random traffic: 100 blocks with input gaps and output stalls
    do_reset();
    blocks = 0;
    for (int i = 0; i < 6000 && blocks < 100; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
    end
    chk("rand_blocks_done", 64'(blocks >= 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
